synapse_accumulator: RTL and testbench
======================================

Name: synapse_accumulator

Overview:
- Upstream feeder for the LIF neuron: converts a per-timestep vector of binary input spikes into one weighted, saturating input current.
- Output is in the neuron's V_SIZE+1 current format, where MSB=1 means overflow/INF.
- Serially accumulates one synapse per cycle against a programmable weight table, then presents the result for exactly one cycle.
- Drives the neuron's current input directly, and drives zero whenever no result is being presented.

Parameters:
- N_IN, 4, number of input synapses (>=2); index width AW = $clog2(N_IN).
- V_SIZE, 4, neuron voltage width; weights are V_SIZE bits, current output is V_SIZE+1 bits.

Ports:
- clk  input  1  clock, all state on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- cfg_we  input  1  weight write enable.
- cfg_addr  input  AW  weight index to write; addresses >= N_IN are ignored.
- cfg_wdata  input  V_SIZE  unsigned weight value.
- step_start  input  1  request to integrate one timestep.
- spikes_in  input  N_IN  input spike vector, sampled with an accepted step_start.
- busy  output  1  high while accumulating.
- step_overrun  output  1  one-cycle pulse: step_start was dropped.
- current_valid  output  1  one-cycle pulse: current_out holds a result.
- current_out  output  V_SIZE+1  weighted current; 0 when current_valid=0.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; weight table, accumulator, index and latched spikes all 0.
  - busy=0, step_overrun=0, current_valid=0, current_out=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - step_start=1 latches spikes_in, sets acc=0 and idx=0, and moves to ACCUM.
  - Otherwise stays in IDLE.
- ACCUM (busy=1):
  - Each cycle, if latched spike[idx]=1, acc <= sat(acc + {0,weight[idx]}); otherwise acc is unchanged.
  - idx increments by 1 each cycle.
  - After processing idx=N_IN-1, moves to DONE. ACCUM lasts exactly N_IN cycles.
- DONE:
  - Registered outputs for exactly one cycle: current_valid=1, current_out=final acc.
  - step_start=1 in DONE is accepted (back-to-back): latches spikes, clears acc/idx, goes to ACCUM. Otherwise goes to IDLE.
  - Sustained throughput is one step per N_IN+1 cycles.
- Latency: step_start sampled at edge E gives current_valid=1 during the cycle following edge E+N_IN+1.
- Saturation, sat(x):
  - Computed at V_SIZE+1 bits.
  - If acc[V_SIZE]=1 or the sum has bit V_SIZE set, the result is INF (all V_SIZE+1 bits = 1).
  - Once acc is INF it stays INF for the rest of the step.
  - Result is never truncated or wrapped.
- Overrun:
  - step_start=1 while in ACCUM is dropped; spikes_in is ignored.
  - step_overrun pulses 1 on the next cycle.
  - The in-progress step is unaffected.
- Weight writes:
  - Accepted in any state and take effect at the next edge.
  - If the entry being written is the one read by ACCUM in the same cycle, the old weight is used.
- When current_valid=0, current_out must be exactly 0, so the neuron sees no input between results.
- Reset asserted mid-ACCUM or in DONE aborts the step immediately: no current_valid pulse, weights cleared. After rstn deasserts, the next step_start starts a fresh step.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan (N_IN=4, V_SIZE=4):
- Basic sum: weights {3,5,2,7}, step_start with spikes=4'b1011 -> busy high 4 cycles, then current_valid=1 for 1 cycle with current_out=5'd15; current_out=0 before and after.
- Saturation: weights {7,7,7,7}, spikes=4'b1111 -> current_out=5'b11111 (INF). Also weights {15,1,0,0}, spikes=4'b0011 -> INF (16 overflows).
- Zero input: spikes=4'b0000 with any weights -> current_valid=1 with current_out=0.
- Overrun and back-to-back:
  - step_start held during ACCUM -> step_overrun pulses and the result is unchanged.
  - step_start asserted in the DONE cycle -> second result appears exactly 5 cycles after the first.
- Write collision: during ACCUM at idx=1, write weight[1]=9 (old value 5), spikes=4'b0010 -> current_out=5. Next step with the same spikes -> current_out=9.
- Reset mid-op: assert rstn=0 at the second ACCUM cycle -> all outputs 0 asynchronously and no valid pulse. After release, spikes=4'b1111 without reloading weights -> current_out=0.

Source files
------------

// File: rtl/synapse_accumulator.sv
// Serial weighted spike accumulator feeding the LIF neuron: one synapse per cycle, saturating to INF.
// Result is presented for one cycle, N_IN+1 cycles after an accepted step; a step_start during accumulation is dropped and flagged.
module synapse_accumulator #(
  parameter int N_IN   = 4,
  parameter int V_SIZE = 4,
  localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [V_SIZE-1:0] cfg_wdata,
  input  logic              step_start,
  input  logic [N_IN-1:0]   spikes_in,
  output logic              busy,
  output logic              step_overrun,
  output logic              current_valid,
  output logic [V_SIZE:0]   current_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);
  localparam logic [AW:0]   N_IN_W   = (AW + 1)'(N_IN);

  state_t              state;
  state_t              state_nxt;
  logic [V_SIZE-1:0]   weight [N_IN];
  logic [N_IN-1:0]     spk;
  logic [AW-1:0]       idx;
  logic [V_SIZE:0]     acc;
  logic [V_SIZE:0]     acc_nxt;
  logic [V_SIZE:0]     sum;
  logic                accept;
  logic                last;

  assign accept = step_start && (state != ACCUM);
  assign last   = (idx == LAST_IDX);

  // Sum is one bit wider than a weight, so a carry into bit V_SIZE marks overflow; INF is sticky.
  always_comb begin
    sum     = acc + {1'b0, weight[idx]};
    acc_nxt = acc;
    if (spk[idx]) begin
      acc_nxt = (acc[V_SIZE] || sum[V_SIZE]) ? '1 : sum;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step_start) state_nxt = ACCUM;
      ACCUM:   if (last) state_nxt = DONE;
      DONE:    state_nxt = step_start ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Writes land at the edge, so an ACCUM read of the same entry in that cycle sees the old weight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_IN; i++) begin
        weight[i] <= '0;
      end
    end else if (cfg_we && ({1'b0, cfg_addr} < N_IN_W)) begin
      weight[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spk <= '0;
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      spk <= spikes_in;
      acc <= '0;
      idx <= '0;
    end else if (state == ACCUM) begin
      acc <= acc_nxt;
      idx <= idx + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy          <= 1'b0;
      step_overrun  <= 1'b0;
      current_valid <= 1'b0;
      current_out   <= '0;
    end else begin
      busy          <= (state_nxt == ACCUM);
      step_overrun  <= step_start && (state == ACCUM);
      current_valid <= (state == DONE);
      current_out   <= (state == DONE) ? acc : '0;
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed bench for synapse_accumulator with a result scoreboard checked by a negedge monitor.
module tb_synapse_accumulator;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_wdata;
  logic       step_start;
  logic [3:0] spikes_in;
  logic       busy;
  logic       step_overrun;
  logic       current_valid;
  logic [4:0] current_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ovr = 0;
  int valid_at = -1;
  int prev_valid_at = -1;
  logic [4:0] exp_q [$];

  synapse_accumulator #(.N_IN(4), .V_SIZE(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .step_start    (step_start),
    .spikes_in     (spikes_in),
    .busy          (busy),
    .step_overrun  (step_overrun),
    .current_valid (current_valid),
    .current_out   (current_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (current_valid) begin
      n_valid++;
      prev_valid_at = valid_at;
      valid_at = cyc;
      check("valid_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("current_out", current_out, exp_q.pop_front());
    end else begin
      check("idle_zero", current_out, 0);
    end
    if (step_overrun) n_ovr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [1:0] a, input logic [3:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_w(input logic [3:0] w0, input logic [3:0] w1,
                        input logic [3:0] w2, input logic [3:0] w3);
    write_w(2'd0, w0); write_w(2'd1, w1); write_w(2'd2, w2); write_w(2'd3, w3);
  endtask

  task automatic step(input logic [3:0] s, input logic [4:0] exp, input string tag);
    int n0, b, t0;
    n0 = n_valid;
    b = 0;
    exp_q.push_back(exp);
    step_start = 1'b1; spikes_in = s;
    tick();
    t0 = cyc;
    step_start = 1'b0; spikes_in = '0;
    repeat (6) begin
      @(negedge clk);
      if (busy) b++;
    end
    tick();
    check({tag, "_busy_cycles"}, b, 4);
    check({tag, "_valid_count"}, n_valid - n0, 1);
    check({tag, "_latency"}, valid_at - t0, 5);
  endtask

  initial begin
    int t0, n0, o0;
    rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    step_start = 1'b0; spikes_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_overrun", step_overrun, 0);
    check("rst_valid", current_valid, 0);
    check("rst_out", current_out, 0);
    @(negedge clk) rstn = 1'b1;
    tick();

    load_w(4'd3, 4'd5, 4'd2, 4'd7);
    step(4'b1011, 5'd15, "basic");
    step(4'b0000, 5'd0, "zero");

    // Back-to-back: second step accepted in the DONE cycle
    n0 = n_valid;
    exp_q.push_back(5'd15);
    step_start = 1'b1; spikes_in = 4'b1011;
    tick();
    t0 = cyc;
    step_start = 1'b0;
    repeat (4) tick();
    check("b2b_busy_in_done", busy, 0);
    exp_q.push_back(5'd3);
    step_start = 1'b1; spikes_in = 4'b0001;
    tick();
    step_start = 1'b0; spikes_in = '0;
    repeat (6) tick();
    check("b2b_first_at", prev_valid_at - t0, 5);
    check("b2b_second_at", valid_at - t0, 10);
    check("b2b_count", n_valid - n0, 2);

    // Overrun: step_start held for two ACCUM cycles with different spikes
    n0 = n_valid;
    o0 = n_ovr;
    exp_q.push_back(5'd2);
    step_start = 1'b1; spikes_in = 4'b0100;
    tick();
    t0 = cyc;
    spikes_in = 4'b1111;
    tick();
    tick();
    step_start = 1'b0; spikes_in = '0;
    repeat (5) tick();
    check("ovr_pulses", n_ovr - o0, 2);
    check("ovr_valid_count", n_valid - n0, 1);
    check("ovr_latency", valid_at - t0, 5);

    // Write collision on the entry being read
    n0 = n_valid;
    exp_q.push_back(5'd5);
    step_start = 1'b1; spikes_in = 4'b0010;
    tick();
    step_start = 1'b0; spikes_in = '0;
    tick();
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 4'd9;
    tick();
    cfg_we = 1'b0;
    repeat (4) tick();
    check("collide_valid_count", n_valid - n0, 1);
    step(4'b0010, 5'd9, "after_write");

    load_w(4'd15, 4'd0, 4'd0, 4'd0);
    step(4'b0001, 5'd15, "max_no_sat");
    load_w(4'd7, 4'd7, 4'd7, 4'd7);
    step(4'b1111, 5'd31, "sat_28");
    load_w(4'd15, 4'd1, 4'd0, 4'd0);
    step(4'b0011, 5'd31, "sat_16");

    // Reset during the second ACCUM cycle
    step_start = 1'b1; spikes_in = 4'b1111;
    tick();
    step_start = 1'b0; spikes_in = '0;
    tick();
    check("pre_rst_busy", busy, 1);
    n0 = n_valid;
    rstn = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", current_valid, 0);
    check("midrst_out", current_out, 0);
    check("midrst_overrun", step_overrun, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (6) tick();
    check("midrst_no_valid", n_valid - n0, 0);
    step(4'b1111, 5'd0, "post_reset");

    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
